// File: rtl/clock_divider_bank_if.sv
// Signal bundle for clock_divider_bank: per-channel enables, shadow-load port, divided outputs.
interface clock_divider_bank_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 28
);
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0] Enable;
   logic                LoadStrobe;
   logic [SELW-1:0]     LoadChannel;
   logic [WIDTH-1:0]    LoadDivisor;
   logic [WIDTH-1:0]    LoadHigh;
   logic [CHANNELS-1:0] ClockOut;
   logic [CHANNELS-1:0] Tick;
   logic [CHANNELS-1:0] Pending;
   logic                LoadError;

   modport master (
      output Enable, LoadStrobe, LoadChannel, LoadDivisor, LoadHigh,
      input  ClockOut, Tick, Pending, LoadError
   );

   modport slave (
      input  Enable, LoadStrobe, LoadChannel, LoadDivisor, LoadHigh,
      output ClockOut, Tick, Pending, LoadError
   );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers; shadow settings are swapped in only at a
// period boundary (or while disabled) so no runt or stretched phase ever reaches ClockOut.
module clock_divider_bank #(
   parameter int CHANNELS        = 4,
   parameter int WIDTH           = 28,
   parameter int DEFAULT_DIVISOR = 2
) (
   input logic                 ClockIn,
   input logic                 Reset,
   clock_divider_bank_if.slave bus
);
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [WIDTH-1:0] DefDivisor = WIDTH'(DEFAULT_DIVISOR);
   localparam logic [WIDTH-1:0] DefHigh    = WIDTH'(DEFAULT_DIVISOR - DEFAULT_DIVISOR / 2);

   logic [WIDTH-1:0] count       [CHANNELS];
   logic [WIDTH-1:0] countNext   [CHANNELS];
   logic [WIDTH-1:0] divisor     [CHANNELS];
   logic [WIDTH-1:0] divisorNext [CHANNELS];
   logic [WIDTH-1:0] high        [CHANNELS];
   logic [WIDTH-1:0] highNext    [CHANNELS];
   logic [WIDTH-1:0] shadowD     [CHANNELS];
   logic [WIDTH-1:0] shadowDNext [CHANNELS];
   logic [WIDTH-1:0] shadowH     [CHANNELS];
   logic [WIDTH-1:0] shadowHNext [CHANNELS];

   logic [CHANNELS-1:0] running, runningNext;
   logic [CHANNELS-1:0] pending, pendingNext;
   logic [CHANNELS-1:0] atBoundary, applyShadow;
   logic [CHANNELS-1:0] clockReg, clockNext;
   logic [CHANNELS-1:0] tickReg, tickNext;
   logic                loadErrReg, loadErrNext;
   logic [WIDTH-1:0]    writeDivisor, writeHigh;
   logic                writeValid;

   // Sanitise on write so the active pair always satisfies 1 <= D and H <= D.
   always_comb begin
      writeDivisor = (bus.LoadDivisor == '0) ? WIDTH'(1) : bus.LoadDivisor;
      writeHigh    = (bus.LoadHigh > writeDivisor) ? writeDivisor : bus.LoadHigh;
      writeValid   = bus.LoadStrobe && (32'(bus.LoadChannel) < CHANNELS);
      loadErrNext  = bus.LoadStrobe && !writeValid;
   end

   always_comb begin
      atBoundary  = '0;
      applyShadow = '0;
      runningNext = bus.Enable;
      pendingNext = pending;
      clockNext   = '0;
      tickNext    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         countNext[i]   = '0;
         divisorNext[i] = divisor[i];
         highNext[i]    = high[i];
         shadowDNext[i] = shadowD[i];
         shadowHNext[i] = shadowH[i];

         atBoundary[i] = running[i] && (count[i] == divisor[i] - WIDTH'(1));
         if (!bus.Enable[i] || atBoundary[i]) begin
            applyShadow[i] = pending[i];
         end else if (running[i]) begin
            countNext[i] = count[i] + WIDTH'(1);
         end

         if (applyShadow[i]) begin
            divisorNext[i] = shadowD[i];
            highNext[i]    = shadowH[i];
            pendingNext[i] = 1'b0;
         end

         // A write in the same cycle as an apply lands in the shadow after the old value moved out.
         if (writeValid && (bus.LoadChannel == SELW'(i))) begin
            shadowDNext[i] = writeDivisor;
            shadowHNext[i] = writeHigh;
            pendingNext[i] = 1'b1;
         end

         clockNext[i] = runningNext[i] && (countNext[i] >= divisorNext[i] - highNext[i]);
         tickNext[i]  = runningNext[i] && (countNext[i] == divisorNext[i] - WIDTH'(1));
      end
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            count[i]   <= '0;
            divisor[i] <= DefDivisor;
            high[i]    <= DefHigh;
            shadowD[i] <= DefDivisor;
            shadowH[i] <= DefHigh;
         end
         running    <= '0;
         pending    <= '0;
         clockReg   <= '0;
         tickReg    <= '0;
         loadErrReg <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            count[i]   <= countNext[i];
            divisor[i] <= divisorNext[i];
            high[i]    <= highNext[i];
            shadowD[i] <= shadowDNext[i];
            shadowH[i] <= shadowHNext[i];
         end
         running    <= runningNext;
         pending    <= pendingNext;
         clockReg   <= clockNext;
         tickReg    <= tickNext;
         loadErrReg <= loadErrNext;
      end
   end

   assign bus.ClockOut  = clockReg;
   assign bus.Tick      = tickReg;
   assign bus.Pending   = pending;
   assign bus.LoadError = loadErrReg;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: directed scenarios plus random traffic against a period-level model.
module tb_clock_divider_bank;
   localparam int CH = 4;
   localparam int W  = 28;

   logic ClockIn = 1'b0;
   logic Reset;
   int   nCompared   = 0;
   int   nMismatched = 0;

   always #5 ClockIn = ~ClockIn;

   clock_divider_bank_if #(.CHANNELS(CH), .WIDTH(W)) busA ();
   clock_divider_bank_if #(.CHANNELS(5),  .WIDTH(8)) busB ();

   clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIVISOR(2)) dutA (
      .ClockIn(ClockIn), .Reset(Reset), .bus(busA));
   clock_divider_bank #(.CHANNELS(5), .WIDTH(8), .DEFAULT_DIVISOR(2)) dutB (
      .ClockIn(ClockIn), .Reset(Reset), .bus(busB));

   // Reference: each channel is "position within the current period" plus settings.
   int mD [CH], mH [CH], mSD [CH], mSH [CH], mPos [CH];
   bit mRun [CH], mPend [CH];
   bit mErr;

   function automatic void model_edge();
      int d;
      bit endOfPeriod;
      if (Reset) begin
         for (int i = 0; i < CH; i++) begin
            mD[i] = 2; mH[i] = 1; mSD[i] = 2; mSH[i] = 1;
            mPos[i] = 0; mRun[i] = 0; mPend[i] = 0;
         end
         mErr = 0;
         return;
      end
      for (int i = 0; i < CH; i++) begin
         endOfPeriod = mRun[i] && (mPos[i] == mD[i] - 1);
         if (!busA.Enable[i] || endOfPeriod) begin
            mPos[i] = 0;
            if (mPend[i]) begin mD[i] = mSD[i]; mH[i] = mSH[i]; mPend[i] = 0; end
         end else begin
            mPos[i] = mRun[i] ? mPos[i] + 1 : 0;
         end
         mRun[i] = busA.Enable[i];
      end
      mErr = busA.LoadStrobe && (int'(busA.LoadChannel) >= CH);
      if (busA.LoadStrobe && int'(busA.LoadChannel) < CH) begin
         d = (busA.LoadDivisor == 0) ? 1 : int'(busA.LoadDivisor);
         mSD[busA.LoadChannel]   = d;
         mSH[busA.LoadChannel]   = (int'(busA.LoadHigh) > d) ? d : int'(busA.LoadHigh);
         mPend[busA.LoadChannel] = 1;
      end
   endfunction

   function automatic logic [CH-1:0] exp_clock();
      logic [CH-1:0] r;
      for (int i = 0; i < CH; i++) r[i] = mRun[i] && (mPos[i] >= mD[i] - mH[i]);
      return r;
   endfunction

   function automatic logic [CH-1:0] exp_tick();
      logic [CH-1:0] r;
      for (int i = 0; i < CH; i++) r[i] = mRun[i] && (mPos[i] == mD[i] - 1);
      return r;
   endfunction

   function automatic logic [CH-1:0] exp_pend();
      logic [CH-1:0] r;
      for (int i = 0; i < CH; i++) r[i] = mPend[i];
      return r;
   endfunction

   task automatic step();
      @(posedge ClockIn);
      model_edge();
      #1;
   endtask

   task automatic drive_load(input int ch, input int d, input int h);
      busA.LoadStrobe  = 1'b1;
      busA.LoadChannel = 2'(ch);
      busA.LoadDivisor = W'(d);
      busA.LoadHigh    = W'(h);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      busA.Enable = 4'b1011;
      drive_load(1, 9, 3);
      repeat (3) step();
      busA.LoadStrobe = 1'b0;
      nCompared++;
      if (busA.ClockOut !== 4'b0) begin nMismatched++; $display("FAIL reset_clock got %b want 0000", busA.ClockOut); end
      nCompared++;
      if (busA.Tick !== 4'b0) begin nMismatched++; $display("FAIL reset_tick got %b want 0000", busA.Tick); end
      nCompared++;
      if (busA.Pending !== 4'b0) begin nMismatched++; $display("FAIL reset_pending got %b want 0000", busA.Pending); end
      nCompared++;
      if (busA.LoadError !== 1'b0) begin nMismatched++; $display("FAIL reset_loaderr got %b want 0", busA.LoadError); end
      nCompared++;
      if ({busB.ClockOut, busB.Tick, busB.Pending} !== 15'b0) begin
         nMismatched++; $display("FAIL reset_bankB got %b/%b/%b want zeros", busB.ClockOut, busB.Tick, busB.Pending);
      end
      Reset = 1'b0;
      busA.Enable = 4'b0000;
      step();
   endtask

   task automatic test_default_toggle();
      busA.Enable = 4'b0001;
      step();
      for (int k = 0; k < 8; k++) begin
         nCompared++;
         if (busA.ClockOut[0] !== 1'(k % 2)) begin
            nMismatched++; $display("FAIL default_clock k=%0d got %b want %0d", k, busA.ClockOut[0], k % 2);
         end
         nCompared++;
         if (busA.Tick[0] !== 1'(k % 2)) begin
            nMismatched++; $display("FAIL default_tick k=%0d got %b want %0d", k, busA.Tick[0], k % 2);
         end
         nCompared++;
         if (busA.Pending !== 4'b0) begin nMismatched++; $display("FAIL default_pending got %b want 0000", busA.Pending); end
         step();
      end
   endtask

   task automatic test_load_ch1();
      int n;
      busA.Enable = 4'b0011;
      step(); step();
      drive_load(1, 5, 2);
      step();
      busA.LoadStrobe = 1'b0;
      nCompared++;
      if (busA.Pending[1] !== 1'b1) begin nMismatched++; $display("FAIL ch1_pending_set got %b want 1", busA.Pending[1]); end
      n = 0;
      while (mPend[1] && n < 10) begin step(); n++; end
      nCompared++;
      if (n >= 10) begin nMismatched++; $display("FAIL ch1_apply_timeout got %0d cycles want <10", n); end
      nCompared++;
      if (busA.Pending[1] !== 1'b0) begin nMismatched++; $display("FAIL ch1_pending_clear got %b want 0", busA.Pending[1]); end
      for (int k = 0; k < 10; k++) begin
         nCompared++;
         if (busA.ClockOut[1] !== 1'((k % 5) >= 3)) begin
            nMismatched++; $display("FAIL ch1_clock k=%0d got %b want %0d", k, busA.ClockOut[1], (k % 5) >= 3);
         end
         nCompared++;
         if (busA.Tick[1] !== 1'((k % 5) == 4)) begin
            nMismatched++; $display("FAIL ch1_tick k=%0d got %b want %0d", k, busA.Tick[1], (k % 5) == 4);
         end
         step();
      end
   endtask

   task automatic test_ch2_clamp();
      int n;
      busA.Enable = 4'b0111;
      step();
      n = 0;
      while (!(mRun[2] && mPos[2] == 1) && n < 8) begin step(); n++; end
      drive_load(2, 0, 7);
      step();
      drive_load(2, 4, 9);
      step();
      busA.LoadStrobe = 1'b0;
      nCompared++;
      if (busA.Pending[2] !== 1'b1) begin nMismatched++; $display("FAIL ch2_pending_held got %b want 1", busA.Pending[2]); end
      step();
      nCompared++;
      if (busA.Pending[2] !== 1'b0) begin nMismatched++; $display("FAIL ch2_pending_clear got %b want 0", busA.Pending[2]); end
      for (int k = 0; k < 8; k++) begin
         nCompared++;
         if (busA.ClockOut[2] !== 1'b1) begin nMismatched++; $display("FAIL ch2_clock_high k=%0d got %b want 1", k, busA.ClockOut[2]); end
         nCompared++;
         if (busA.Tick[2] !== 1'((k % 4) == 3)) begin
            nMismatched++; $display("FAIL ch2_tick k=%0d got %b want %0d", k, busA.Tick[2], (k % 4) == 3);
         end
         step();
      end
   endtask

   task automatic test_boundary_write();
      int n;
      n = 0;
      while (!(mRun[0] && mPos[0] == 0) && n < 8) begin step(); n++; end
      drive_load(0, 3, 1);
      step();
      drive_load(0, 6, 3);
      step();
      busA.LoadStrobe = 1'b0;
      for (int k = 0; k < 3; k++) begin
         nCompared++;
         if (busA.Pending[0] !== 1'b1) begin nMismatched++; $display("FAIL bwr_pending_held k=%0d got %b want 1", k, busA.Pending[0]); end
         nCompared++;
         if (busA.ClockOut[0] !== 1'(k >= 2) || busA.Tick[0] !== 1'(k == 2)) begin
            nMismatched++; $display("FAIL bwr_old_shadow k=%0d got clk=%b tick=%b want clk=%0d tick=%0d",
                                    k, busA.ClockOut[0], busA.Tick[0], k >= 2, k == 2);
         end
         step();
      end
      nCompared++;
      if (busA.Pending[0] !== 1'b0) begin nMismatched++; $display("FAIL bwr_pending_clear got %b want 0", busA.Pending[0]); end
      for (int k = 0; k < 6; k++) begin
         nCompared++;
         if (busA.ClockOut[0] !== 1'(k >= 3) || busA.Tick[0] !== 1'(k == 5)) begin
            nMismatched++; $display("FAIL bwr_new_shadow k=%0d got clk=%b tick=%b want clk=%0d tick=%0d",
                                    k, busA.ClockOut[0], busA.Tick[0], k >= 3, k == 5);
         end
         step();
      end
   endtask

   task automatic test_disable_reset();
      busA.Enable = 4'b1111;
      step();
      drive_load(3, 7, 3);
      step();
      busA.LoadStrobe = 1'b0;
      busA.Enable = 4'b0111;
      nCompared++;
      if (busA.Pending[3] !== 1'b1) begin nMismatched++; $display("FAIL ch3_pending_set got %b want 1", busA.Pending[3]); end
      step();
      nCompared++;
      if ({busA.ClockOut[3], busA.Tick[3], busA.Pending[3]} !== 3'b000) begin
         nMismatched++; $display("FAIL ch3_disable got clk=%b tick=%b pend=%b want 000", busA.ClockOut[3], busA.Tick[3], busA.Pending[3]);
      end
      busA.Enable = 4'b1111;
      step();
      for (int k = 0; k < 7; k++) begin
         nCompared++;
         if (busA.ClockOut[3] !== 1'(k >= 4) || busA.Tick[3] !== 1'(k == 6)) begin
            nMismatched++; $display("FAIL ch3_applied k=%0d got clk=%b tick=%b want clk=%0d tick=%0d",
                                    k, busA.ClockOut[3], busA.Tick[3], k >= 4, k == 6);
         end
         step();
      end
      drive_load(1, 9, 4);
      step();
      busA.LoadStrobe = 1'b0;
      Reset = 1'b1;
      step();
      nCompared++;
      if ({busA.ClockOut, busA.Tick, busA.Pending} !== 12'b0) begin
         nMismatched++; $display("FAIL midreset_outputs got %b/%b/%b want zeros", busA.ClockOut, busA.Tick, busA.Pending);
      end
      Reset = 1'b0;
      busA.Enable = 4'b0001;
      step();
      nCompared++;
      if (busA.ClockOut !== 4'b0000 || busA.Tick !== 4'b0000) begin
         nMismatched++; $display("FAIL restart_first got %b/%b want 0000/0000", busA.ClockOut, busA.Tick);
      end
      step();
      nCompared++;
      if (busA.ClockOut !== 4'b0001 || busA.Tick !== 4'b0001) begin
         nMismatched++; $display("FAIL restart_second got %b/%b want 0001/0001", busA.ClockOut, busA.Tick);
      end
   endtask

   task automatic test_load_error();
      busB.Enable = 5'b10000;
      step(); step();
      busB.LoadStrobe = 1'b1; busB.LoadChannel = 3'd4; busB.LoadDivisor = 8'd200; busB.LoadHigh = 8'd100;
      step();
      busB.LoadStrobe = 1'b0;
      nCompared++;
      if (busB.Pending !== 5'b10000 || busB.LoadError !== 1'b0) begin
         nMismatched++; $display("FAIL lerr_valid_write got pend=%b err=%b want 10000/0", busB.Pending, busB.LoadError);
      end
      repeat (3) step();
      nCompared++;
      if (busB.Pending !== 5'b00000) begin nMismatched++; $display("FAIL lerr_first_apply got %b want 00000", busB.Pending); end
      busB.LoadStrobe = 1'b1; busB.LoadDivisor = 8'd3; busB.LoadHigh = 8'd1;
      step();
      busB.LoadChannel = 3'd5;
      step();
      busB.LoadStrobe = 1'b0;
      nCompared++;
      if (busB.LoadError !== 1'b1 || busB.Pending !== 5'b10000) begin
         nMismatched++; $display("FAIL lerr_ch5 got err=%b pend=%b want 1/10000", busB.LoadError, busB.Pending);
      end
      step();
      nCompared++;
      if (busB.LoadError !== 1'b0) begin nMismatched++; $display("FAIL lerr_one_cycle got %b want 0", busB.LoadError); end
      busB.LoadStrobe = 1'b1; busB.LoadChannel = 3'd7; busB.LoadDivisor = 8'd1;
      step();
      busB.LoadStrobe = 1'b0;
      nCompared++;
      if (busB.LoadError !== 1'b1 || busB.Pending !== 5'b10000) begin
         nMismatched++; $display("FAIL lerr_ch7 got err=%b pend=%b want 1/10000", busB.LoadError, busB.Pending);
      end
      step();
      nCompared++;
      if (busB.LoadError !== 1'b0 || busB.Pending !== 5'b10000) begin
         nMismatched++; $display("FAIL lerr_after got err=%b pend=%b want 0/10000", busB.LoadError, busB.Pending);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         Reset = ($urandom_range(0, 79) == 0);
         for (int i = 0; i < CH; i++)
            if ($urandom_range(0, 15) == 0) busA.Enable[i] = ~busA.Enable[i];
         if ($urandom_range(0, 3) == 0)
            drive_load($urandom_range(0, CH - 1), $urandom_range(0, 9), $urandom_range(0, 11));
         else
            busA.LoadStrobe = 1'b0;
         step();
         nCompared++;
         if (busA.ClockOut !== exp_clock()) begin
            nMismatched++; $display("FAIL rand_clock c=%0d got %b want %b", c, busA.ClockOut, exp_clock());
         end
         nCompared++;
         if (busA.Tick !== exp_tick()) begin
            nMismatched++; $display("FAIL rand_tick c=%0d got %b want %b", c, busA.Tick, exp_tick());
         end
         nCompared++;
         if (busA.Pending !== exp_pend()) begin
            nMismatched++; $display("FAIL rand_pending c=%0d got %b want %b", c, busA.Pending, exp_pend());
         end
         nCompared++;
         if (busA.LoadError !== mErr) begin
            nMismatched++; $display("FAIL rand_loaderr c=%0d got %b want %b", c, busA.LoadError, mErr);
         end
      end
      Reset = 1'b0;
      busA.LoadStrobe = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset            = 1'b1;
      busA.Enable      = '0;
      busA.LoadStrobe  = 1'b0;
      busA.LoadChannel = '0;
      busA.LoadDivisor = '0;
      busA.LoadHigh    = '0;
      busB.Enable      = '0;
      busB.LoadStrobe  = 1'b0;
      busB.LoadChannel = '0;
      busB.LoadDivisor = '0;
      busB.LoadHigh    = '0;
      test_reset();
      test_default_toggle();
      test_load_ch1();
      test_ch2_clamp();
      test_boundary_write();
      test_disable_reset();
      test_load_error();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
